// File: rtl/debug_buttons_pkg.sv
// Shared types for the button-driven LED writer and the LED device it feeds.
package debug_buttons_pkg;

  localparam int LED_STATE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } wb_ctrl_state_e;

  // Colour word understood by the downstream LED device.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_led_t;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, stability counter, debounced level and
// a one-cycle pulse on each debounced 0->1 transition.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it has differed from the
  // debounced level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync    <= '0;
      cnt     <= '0;
      level_o <= 1'b0;
      press_o <= 1'b0;
    end else begin
      sync    <= {sync[0], raw_i};
      press_o <= 1'b0;
      if (sync[1] == level_o) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level_o <= sync[1];
        press_o <= sync[1];
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_wb_writer.sv
// Folds debounced button presses into an 8-bit LED state and pushes every
// change to the LED device as a single pipelined Wishbone write.
module button_wb_writer
  import debug_buttons_pkg::*;
#(
  parameter int          NUM_BUTTONS     = 4,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter logic [31:0] LED_ADDR        = 32'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_BUTTONS-1:0] buttons_i,
  output logic                   cyc_o,
  output logic                   stb_o,
  output logic                   we_o,
  output logic [31:0]            adr_o,
  output logic [LED_STATE_W-1:0] dat_o,
  input  logic                   ack_i,
  input  logic                   stall_i,
  input  logic                   err_i,
  output logic [LED_STATE_W-1:0] led_state_o,
  output logic [3:0]             err_count_o
);

  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] press;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (buttons_i[g]),
      .level_o (level[g]),
      .press_o (press[g])
    );
  end

  wb_ctrl_state_e         state, state_nxt;
  logic                   pending, pending_nxt;
  logic                   take, err_hit;
  logic [LED_STATE_W-1:0] led_nxt;
  logic [3:0]             cnt_add;

  // Apply all presses of this cycle at once: low nibble toggles, high nibble
  // counts presses modulo 16.
  always_comb begin
    led_nxt = led_state_o;
    cnt_add = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (i < 4) led_nxt[i] = led_state_o[i] ^ press[i];
      cnt_add = cnt_add + 4'(press[i]);
    end
    led_nxt[7:4] = led_state_o[7:4] + cnt_add;
  end

  // Next state: snapshot in IDLE, issue in REQ, wait for ack/err in WAIT.
  // An err (which wins over ack) re-arms pending so the current state is
  // rewritten.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    err_hit   = 1'b0;
    case (state)
      IDLE: if (pending) begin
        take      = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (!stall_i) begin
        if (err_i) begin
          err_hit   = 1'b1;
          state_nxt = IDLE;
        end else if (ack_i) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (err_i) begin
          err_hit   = 1'b1;
          state_nxt = IDLE;
        end else if (ack_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A press in the snapshot cycle must still produce a follow-up write.
    pending_nxt = pending;
    if (take) pending_nxt = 1'b0;
    if (|press || err_hit) pending_nxt = 1'b1;
  end

  // Bus outputs decode straight from the state register so reset drops them
  // without waiting for a clock.
  assign cyc_o = (state != IDLE);
  assign stb_o = (state == REQ);
  assign we_o  = cyc_o;
  assign adr_o = cyc_o ? LED_ADDR : 32'h0;

  // State register, LED word, pending flag, write snapshot and error counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pending     <= 1'b1;
      led_state_o <= '0;
      dat_o       <= '0;
      err_count_o <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      led_state_o <= led_nxt;
      if (take) dat_o <= led_state_o;
      if (err_hit && err_count_o != 4'hF) err_count_o <= err_count_o + 1'b1;
    end
  end

endmodule
